double_trouble_core: RTL and testbench
======================================

// Module: double_trouble_core
// PURPOSE
//  4-input threshold detector. out = 1 when at least THRESHOLD of a,b,c,d are 1.
//    The default THRESHOLD is 2, so out = 1 for "two or more inputs high".
//  Sits in the logic-gate primitive layer as a combinational voter.
//  Also provides a registered copy of out and a saturating hit counter for
//    monitoring logic that runs on the system clock.
// PARAMETERS
//  THRESHOLD  2  minimum number of 1 inputs that asserts out; legal range 1..4
//  CNT_W      8  width of the hits counter
// PORTS
//  clk    in   1      system clock, rising edge
//  rst    in   1      reset: synchronous, active-high
//  a      in   1      vote input 0
//  b      in   1      vote input 1
//  c      in   1      vote input 2
//  d      in   1      vote input 3
//  out    out  1      combinational: (a+b+c+d) >= THRESHOLD
//  count  out  3      combinational population count of {a,b,c,d}; range 0..4
//  out_q  out  1      out registered on clk
//  hits   out  CNT_W  saturating count of clk edges sampled with out=1
// BEHAVIOUR
//  - out and count are purely combinational.
//    - They do not depend on clk or rst, and are valid with no clock running.
//    - They settle within one delta after any input change.
//  - Truth table at THRESHOLD=2: out=0 for the 0000 and single-hot patterns.
//    - Single-hot patterns: 1000, 0100, 0010, 0001.
//    - out=1 for the other 11 patterns.
//  - No X is propagated when all inputs are known.
//  - Registered outputs:
//    - Reset values: out_q = 0, hits = 0.
//    - Rising clk with rst = 1: out_q <= 0, hits <= 0. Reset takes priority.
//    - Rising clk with rst = 0: out_q <= out, with 1-cycle latency.
//    - Rising clk with rst = 0 and out = 1: hits <= hits + 1.
//    - hits saturates at 2^CNT_W-1 and never wraps.
//  - Reset asserted mid-run clears out_q and hits on the next edge only.
//    - out and count are unaffected by reset.
//  - THRESHOLD outside 1..4 is a compile-time error: elaboration $error via a generate check.
// CONFIGURATION
//  Macro DOUBLE_TROUBLE_STICKY_EN.
//  - Defined: adds output port sticky (1 bit).
//    - sticky <= 1 on the first clk edge with out=1.
//    - It then holds at 1 until rst.
//    - Reset value 0.
//  - Undefined: no sticky port and no sticky flop. All other behaviour is identical.
// STRUCTURE
//  Package double_trouble_pkg:
//    - NUM_IN=4
//    - DEFAULT_THRESHOLD=2
//    - CNT_W_DEFAULT=8
//    - function popcnt4
//  Sub-module popcount4:
//    - Input 4-bit vector, output 3-bit count.
//    - Pure combinational logic.
//  Top level:
//    - compares count >= THRESHOLD;
//    - holds the out_q and hits flops plus the optional sticky flop.
// TESTING
//  1. Exhaustive combinational check, no clock running.
//     - Drive all 16 abcd patterns, 10 ns each.
//     - Expect out = 1 exactly when popcount >= 2.
//     - Example: 0000->0, 1000->0, 1100->1, 1111->1.
//     - Expect count to match popcount.
//  2. Reset: hold rst=1 for 2 edges with abcd=1111.
//     - Expect out_q=0 and hits=0.
//     - Expect out=1 and count=4 throughout.
//  3. Latency: with rst=0, step abcd 0001 -> 0011.
//     - Expect out to rise immediately.
//     - Expect out_q to rise at the next clk edge.
//  4. Saturation at CNT_W=2: hold abcd=1010 for 6 edges.
//     - Expect hits to go 1,2,3,3,3,3.
//  5. Mid-run reset: hits=5, then assert rst for 1 edge with out=1.
//     - Expect hits=0.
//     - Expect hits=1 on the next edge after rst is released.
//  6. With DOUBLE_TROUBLE_STICKY_EN defined: pulse abcd=0110 for one edge, then abcd=0000.
//     - Expect sticky to stay 1 until rst.

Source files
------------

// File: rtl/double_trouble_pkg.sv
// Shared constants and helper for the double_trouble threshold voter.
package double_trouble_pkg;

  localparam int NUM_IN            = 4;
  localparam int DEFAULT_THRESHOLD = 2;
  localparam int CNT_W_DEFAULT     = 8;

  // Zero-extend each bit before summing so the carry into bit 2 is kept.
  function automatic logic [2:0] popcnt4(input logic [NUM_IN-1:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/popcount4.sv
// Combinational population count of a 4-bit vote vector.
module popcount4
  import double_trouble_pkg::*;
(
  input  logic [NUM_IN-1:0] vec,
  output logic [2:0]        cnt
);

  always_comb begin
    cnt = popcnt4(vec);
  end

endmodule

// File: rtl/double_trouble_core.sv
// 4-input threshold voter with registered copy and saturating hit counter.
// Optional sticky hit flag when DOUBLE_TROUBLE_STICKY_EN is defined.
module double_trouble_core
  import double_trouble_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             out,
  output logic [2:0]       count,
  output logic             out_q,
  output logic [CNT_W-1:0] hits
`ifdef DOUBLE_TROUBLE_STICKY_EN
  ,
  output logic             sticky
`endif
);

  if (THRESHOLD < 1 || THRESHOLD > NUM_IN) begin : g_bad_threshold
    $error("double_trouble_core: THRESHOLD must be in 1..4");
  end

  localparam logic [2:0]       ThrW    = 3'(THRESHOLD);
  localparam logic [CNT_W-1:0] HitsMax = '1;
  localparam logic [CNT_W-1:0] HitsOne = CNT_W'(1);

  logic [NUM_IN-1:0] vec;
  logic              out_d;
  logic              out_q_q;
  logic [CNT_W-1:0]  hits_d, hits_q;

  assign vec = {d, c, b, a};

  popcount4 u_popcount4 (
    .vec (vec),
    .cnt (count)
  );

  assign out = (count >= ThrW);

  always_comb begin
    out_d  = out;
    hits_d = hits_q;
    if (out && (hits_q != HitsMax)) begin
      hits_d = hits_q + HitsOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q_q <= 1'b0;
      hits_q  <= '0;
    end else begin
      out_q_q <= out_d;
      hits_q  <= hits_d;
    end
  end

  assign out_q = out_q_q;
  assign hits  = hits_q;

`ifdef DOUBLE_TROUBLE_STICKY_EN
  logic sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_q | out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_double_trouble_core.sv
// Directed self-checking bench for double_trouble_core (default and CNT_W=2 builds).
module tb_double_trouble_core;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       out, out_s;
  logic [2:0] count, count_s;
  logic       out_q, out_q_s;
  logic [7:0] hits;
  logic [1:0] hits_s;
`ifdef DOUBLE_TROUBLE_STICKY_EN
  logic       sticky, sticky_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 if (clk_en) clk = ~clk;

  double_trouble_core u_dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .out   (out),
    .count (count),
    .out_q (out_q),
    .hits  (hits)
`ifdef DOUBLE_TROUBLE_STICKY_EN
    ,
    .sticky(sticky)
`endif
  );

  double_trouble_core #(.THRESHOLD(2), .CNT_W(2)) u_dut_small (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .out   (out_s),
    .count (count_s),
    .out_q (out_q_s),
    .hits  (hits_s)
`ifdef DOUBLE_TROUBLE_STICKY_EN
    ,
    .sticky(sticky_s)
`endif
  );

  // Pattern string order is abcd, so p[3] drives a.
  task automatic set_abcd(input logic [3:0] p);
    a = p[3];
    b = p[2];
    c = p[1];
    d = p[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb();
    int          exp_cnt[16] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};
    logic        exp_out[16] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 16; i++) begin
      set_abcd(4'(i));
      #10;
      n_checks++;
      if (out !== exp_out[i]) begin
        n_fail++;
        $display("FAIL comb_out pattern=%b got=%b want=%b", 4'(i), out, exp_out[i]);
      end
      n_checks++;
      if (count !== 3'(exp_cnt[i])) begin
        n_fail++;
        $display("FAIL comb_count pattern=%b got=%0d want=%0d", 4'(i), count, exp_cnt[i]);
      end
      n_checks++;
      if (out_s !== exp_out[i]) begin
        n_fail++;
        $display("FAIL comb_out_small pattern=%b got=%b want=%b", 4'(i), out_s, exp_out[i]);
      end
    end
  endtask

  task automatic test_reset();
    set_abcd(4'b1111);
    rst = 1'b1;
    clk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (out_q !== 1'b0 || hits !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_regs edge=%0d got out_q=%b hits=%0d want 0/0", i, out_q, hits);
      end
      n_checks++;
      if (out !== 1'b1 || count !== 3'd4) begin
        n_fail++;
        $display("FAIL reset_comb edge=%0d got out=%b count=%0d want 1/4", i, out, count);
      end
      n_checks++;
      if (out_q_s !== 1'b0 || hits_s !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_small got out_q=%b hits=%0d want 0/0", out_q_s, hits_s);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    set_abcd(4'b0001);
    tick();
    n_checks++;
    if (out !== 1'b0 || out_q !== 1'b0 || hits !== 8'd0) begin
      n_fail++;
      $display("FAIL lat_low got out=%b out_q=%b hits=%0d want 0/0/0", out, out_q, hits);
    end
    set_abcd(4'b0011);
    #1;
    n_checks++;
    if (out !== 1'b1 || out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_immediate got out=%b out_q=%b want 1/0", out, out_q);
    end
    tick();
    n_checks++;
    if (out_q !== 1'b1 || hits !== 8'd1) begin
      n_fail++;
      $display("FAIL lat_edge got out_q=%b hits=%0d want 1/1", out_q, hits);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pats[5]   = '{4'b1100, 4'b0100, 4'b0111, 4'b0000, 4'b1111};
    logic       exp_oq[5] = '{1, 0, 1, 0, 1};
    int         exp_h[5]  = '{1, 1, 2, 2, 3};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_abcd(pats[i]);
      tick();
      n_checks++;
      if (out_q !== exp_oq[i] || hits !== 8'(exp_h[i])) begin
        n_fail++;
        $display("FAIL b2b step=%0d got out_q=%b hits=%0d want %b/%0d",
                 i, out_q, hits, exp_oq[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_s[6] = '{1, 2, 3, 3, 3, 3};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_abcd(4'b1010);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (hits_s !== 2'(exp_s[i])) begin
        n_fail++;
        $display("FAIL sat_small edge=%0d got=%0d want=%0d", i, hits_s, exp_s[i]);
      end
      n_checks++;
      if (hits !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL sat_big edge=%0d got=%0d want=%0d", i, hits, i + 1);
      end
    end
  endtask

  task automatic test_midrun_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_abcd(4'b1010);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (hits !== 8'd5) begin
      n_fail++;
      $display("FAIL mid_preload got=%0d want=5", hits);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (hits !== 8'd0 || out_q !== 1'b0 || out !== 1'b1 || count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_reset got hits=%0d out_q=%b out=%b count=%0d want 0/0/1/2",
               hits, out_q, out, count);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (hits !== 8'd1 || out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release got hits=%0d out_q=%b want 1/1", hits, out_q);
    end
  endtask

`ifdef DOUBLE_TROUBLE_STICKY_EN
  task automatic test_sticky();
    rst = 1'b1;
    set_abcd(4'b0000);
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_idle got=%b want=0", sticky);
    end
    set_abcd(4'b0110);
    tick();
    set_abcd(4'b0000);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sticky !== 1'b1 || sticky_s !== 1'b1) begin
        n_fail++;
        $display("FAIL sticky_hold cycle=%0d got=%b/%b want=1", i, sticky, sticky_s);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear got=%b want=0", sticky);
    end
  endtask
`endif

  initial begin
    test_comb();
    test_reset();
    test_latency();
    test_back_to_back();
    test_saturation();
    test_midrun_reset();
`ifdef DOUBLE_TROUBLE_STICKY_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
